// File: rtl/mem_bus_bridge.sv
// Data-memory bridge: core load/store requests -> registered Avalon-MM transactions.
// Optional waitrequest timeout is compiled in with `define MEM_BRIDGE_TIMEOUT_EN.
module mem_bus_bridge #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_writedata,
  input  logic [1:0]  cpu_size,
  output logic [31:0] cpu_readdata,
  output logic        cpu_stall,
  output logic        cpu_error,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [1:0]  dbg_state_o
);

  if (WAIT_LIMIT < 1 || WAIT_LIMIT > 255) begin : g_bad_wait_limit
    $error("mem_bus_bridge: WAIT_LIMIT must be 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req;
  logic        illegal;
  logic [3:0]  be_lane;
  logic [31:0] wdata_lane;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  assign req     = cpu_read | cpu_write;
  assign illegal = (cpu_read & cpu_write) | (cpu_size == 2'b11) |
                   ((cpu_size == 2'b10) & (|cpu_address[1:0])) |
                   ((cpu_size == 2'b01) & cpu_address[0]);

  // Lane steering from the low address bits; unused lanes stay zero.
  always_comb begin
    be_lane    = 4'b0000;
    wdata_lane = 32'h0;
    case (cpu_size)
      2'b00: begin
        be_lane    = 4'b0001 << cpu_address[1:0];
        wdata_lane = {24'h0, cpu_writedata[7:0]} << {cpu_address[1:0], 3'b000};
      end
      2'b01: begin
        be_lane    = cpu_address[1] ? 4'b1100 : 4'b0011;
        wdata_lane = cpu_address[1] ? {cpu_writedata[15:0], 16'h0}
                                    : {16'h0, cpu_writedata[15:0]};
      end
      2'b10: begin
        be_lane    = 4'b1111;
        wdata_lane = cpu_writedata;
      end
      default: begin
        be_lane    = 4'b0000;
        wdata_lane = 32'h0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    rdata_d = rdata_q;
    err_d   = 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (illegal) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            addr_d  = {cpu_address[31:2], 2'b00};
            wdata_d = wdata_lane;
            be_d    = be_lane;
            rd_d    = cpu_read;
            wr_d    = cpu_write;
            state_d = ST_REQ;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
          end
        end
      end
      ST_REQ: begin
        if (!avm_waitrequest) begin
          if (rd_q) rdata_d = avm_readdata;
          state_d = ST_DONE;
`ifdef MEM_BRIDGE_TIMEOUT_EN
        end else if (cnt_q == WAIT_LAST) begin
          // The WAIT_LIMIT-th stalled cycle ends here: abandon the access.
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          rd_d    = rd_q;
          wr_d    = wr_q;
          cnt_d   = cnt_q + 8'd1;
        end
`else
        end else begin
          rd_d    = rd_q;
          wr_d    = wr_q;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef MEM_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign cpu_stall      = reset & (((state_q == ST_IDLE) & req) | (state_q == ST_REQ));
  assign cpu_error      = err_q;
  assign cpu_readdata   = rdata_q;
  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Randomized bench for mem_bus_bridge against a transaction-level reference model.
module tb_mem_bus_bridge;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int  WL    = 4;
  localparam bit  TO_EN = 1'b1;
`else
  localparam int  WL    = 255;
  localparam bit  TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_address, cpu_writedata;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_readdata;
  logic        cpu_stall, cpu_error;
  logic [31:0] avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [1:0]  dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_rdata;

  mem_bus_bridge #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_writedata(cpu_writedata), .cpu_size(cpu_size),
    .cpu_readdata(cpu_readdata), .cpu_stall(cpu_stall), .cpu_error(cpu_error),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One core memory instruction: drive it in IDLE and check every cycle until DONE.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size,
                         input int nwait, input logic [31:0] rdata);
    bit          legal, abort;
    int          nbytes, off, req_cycles;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    nbytes = 1 << size;
    off    = int'(addr[1:0]);
    legal  = !(rd && wr) && (size != 2'b11) && ((off % nbytes) == 0);
    exp_be = 4'h0;
    exp_wd = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (legal && i >= off && i < off + nbytes) begin
        exp_be[i]       = 1'b1;
        exp_wd[8*i +: 8] = wdata[8*(i-off) +: 8];
      end
    end
    abort      = TO_EN && legal && (nwait >= WL);
    req_cycles = abort ? WL : nwait + 1;

    @(negedge clk);
    cpu_read = rd; cpu_write = wr; cpu_address = addr;
    cpu_writedata = wdata; cpu_size = size;
    avm_waitrequest = 1'b1; avm_readdata = $urandom;
    #1;
    check("idle_stall", {31'h0, cpu_stall}, 32'd1);
    check("idle_strobe", {30'h0, avm_read, avm_write}, 32'd0);

    if (legal) begin
      for (int k = 0; k < req_cycles; k++) begin
        @(negedge clk);
        avm_waitrequest = abort || (k < nwait);
        avm_readdata    = (!abort && k == nwait) ? rdata : $urandom;
        #1;
        check("req_stall", {31'h0, cpu_stall}, 32'd1);
        check("req_read", {31'h0, avm_read}, {31'h0, rd});
        check("req_write", {31'h0, avm_write}, {31'h0, wr});
        check("req_addr", avm_address, {addr[31:2], 2'b00});
        check("req_be", {28'h0, avm_byteenable}, {28'h0, exp_be});
        if (wr) check("req_wdata", avm_writedata, exp_wd);
        check("req_err", {31'h0, cpu_error}, 32'd0);
      end
    end

    @(negedge clk);
    cpu_read = 1'b0; cpu_write = 1'b0; avm_waitrequest = 1'b0; avm_readdata = $urandom;
    #1;
    if (legal && !abort && rd) model_rdata = rdata;
    check("done_stall", {31'h0, cpu_stall}, 32'd0);
    check("done_err", {31'h0, cpu_error}, {31'h0, (!legal || abort)});
    check("done_strobe", {30'h0, avm_read, avm_write}, 32'd0);
    check("done_rdata", cpu_readdata, model_rdata);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    cpu_read = 1'b0; cpu_write = 1'b0;
    #1;
    check("gap_stall", {31'h0, cpu_stall}, 32'd0);
    check("gap_err", {31'h0, cpu_error}, 32'd0);
    check("gap_strobe", {30'h0, avm_read, avm_write}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 32'h0;
    cpu_writedata = 32'h0; cpu_size = 2'b10; avm_waitrequest = 1'b0; avm_readdata = 32'h0;
    model_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", {31'h0, cpu_stall}, 32'd0);
    check("rst_strobe", {30'h0, avm_read, avm_write}, 32'd0);
    check("rst_rdata", cpu_readdata, 32'h0);
    check("rst_err", {31'h0, cpu_error}, 32'd0);
    check("rst_addr", avm_address, 32'h0);
    check("rst_be", {28'h0, avm_byteenable}, 32'h0);
    cpu_read = 1'b0;
    reset = 1'b1;
    idle_cycle();

    // Directed cases from the test plan.
    run_txn(1, 0, 32'h0000_0100, 32'h0, 2'b10, 0, 32'h1234_5678);
    run_txn(0, 1, 32'h0000_0013, 32'h0000_00AB, 2'b00, 0, 32'h0);
    run_txn(1, 0, 32'h0000_0022, 32'h0, 2'b01, 2, 32'hCAFE_F00D);
    run_txn(1, 0, 32'h0000_0102, 32'h0, 2'b10, 0, 32'hDEAD_BEEF);
    run_txn(1, 0, 32'h0000_0200, 32'h0, 2'b10, 6, 32'h5555_AAAA);
    run_txn(0, 1, 32'h0000_0204, 32'h8765_4321, 2'b10, 1, 32'h0);
    run_txn(1, 1, 32'h0000_0300, 32'h0, 2'b10, 0, 32'h0);
    run_txn(1, 0, 32'h0000_0301, 32'h0, 2'b01, 0, 32'h0);
    run_txn(0, 1, 32'h0000_0300, 32'h0, 2'b11, 0, 32'h0);
    idle_cycle();

    // Reset while a write is stalled in REQ.
    @(negedge clk);
    cpu_write = 1'b1; cpu_address = 32'h0000_0040; cpu_size = 2'b10;
    cpu_writedata = 32'h1111_2222; avm_waitrequest = 1'b1;
    @(negedge clk);
    #1;
    check("rstreq_write", {31'h0, avm_write}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstreq_stall", {31'h0, cpu_stall}, 32'd0);
    @(negedge clk);
    cpu_write = 1'b0; reset = 1'b1;
    #1;
    model_rdata = 32'h0;
    check("rstreq_strobe", {30'h0, avm_read, avm_write}, 32'd0);
    check("rstreq_rdata", cpu_readdata, model_rdata);
    check("rstreq_idle_stall", {31'h0, cpu_stall}, 32'd0);
    run_txn(1, 0, 32'h0000_0080, 32'h0, 2'b10, 0, 32'h0BAD_CAFE);

    // Random back-to-back traffic with occasional idle gaps.
    for (int t = 0; t < 250; t++) begin
      int          kind, nw;
      logic [31:0] a;
      logic [1:0]  sz;
      kind = $urandom_range(0, 19);
      a    = $urandom;
      sz   = 2'($urandom_range(0, 3));
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      nw   = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      run_txn(kind == 0 || kind >= 11, kind >= 1 && kind <= 10 || kind == 0,
              a, $urandom, sz, nw, $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
